adq_seq_ctrl: RTL and testbench

Sequencer for the ADC acquisition path. On an init request it runs N_SAMPLES conversion cycles: start-conversion pulse, wait for end-of-conversion, read strobe, sample-memory write. It returns a four-phase init/ack handshake to the host side and flags an EOC timeout. It sits between the host control logic and the ADC plus sample buffer, and drives the sample-address counter.

---
 rtl/adq_pkg.sv | 20 ++
 rtl/adq_sample_counter.sv | 31 +++
 rtl/adq_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_adq_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adq_pkg.sv
// Shared types and default constants for the ADC acquisition sequencer.
package adq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_EOC = 3'd2,
    READ     = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } adq_state_t;

  localparam int N_SAMPLES_DEF   = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int SC_CYCLES_DEF   = 2;
  localparam int EOC_TIMEOUT_DEF = 255;

endpackage

// File: rtl/adq_sample_counter.sv
// Sample-address up-counter: synchronous clear, enable, saturates at LIMIT-1
// and flags that terminal value on tc.
module adq_sample_counter
  import adq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LIMIT  = N_SAMPLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LIMIT - 1);

  assign tc = (count == LAST);

  // Count register; holds at LAST so the address never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !tc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/adq_seq_ctrl.sv
// ADC acquisition sequencer: runs N_SAMPLES start/wait/read/write cycles per
// init request, answers with a four-phase ack and flags EOC timeouts.
module adq_seq_ctrl
  import adq_pkg::*;
#(
  parameter int N_SAMPLES   = N_SAMPLES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SC_CYCLES   = SC_CYCLES_DEF,
  parameter int EOC_TIMEOUT = EOC_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              abort,
  input  logic              eoc,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sc,
  output logic              cs,
  output logic              rc,
  output logic              w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int TMR_W = $clog2(EOC_TIMEOUT + 1);
  localparam int SC_W  = $clog2(SC_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EOC_TIMEOUT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SC_CYCLES - 1);

  adq_state_t        state;
  adq_state_t        nxt;
  logic [SC_W-1:0]   sc_cnt;
  logic [TMR_W-1:0]  timer;
  logic              err_q;
  logic [ADDR_W-1:0] count;
  logic              tc;
  logic              cnt_clr;
  logic              cnt_en;

  adq_sample_counter #(
    .ADDR_W (ADDR_W),
    .LIMIT  (N_SAMPLES)
  ) u_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next-state decode; abort takes priority over eoc and timeout in active states.
  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        if (init) begin
          nxt     = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (abort)
          nxt = IDLE;
        else if (sc_cnt == SC_LAST)
          nxt = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (abort)
          nxt = IDLE;
        else if (eoc)
          nxt = READ;
        else if (timer == TMR_LAST)
          nxt = ERR;
      end
      READ: begin
        nxt = abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (abort)
          nxt = IDLE;
        else if (tc)
          nxt = DONE;
        else begin
          nxt    = START;
          cnt_en = 1'b1;
        end
      end
      DONE, ERR: begin
        if (!init)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Start-conversion pulse length counter; zero whenever leaving START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sc_cnt <= '0;
    else if (state == START && nxt == START)
      sc_cnt <= sc_cnt + 1'b1;
    else
      sc_cnt <= '0;
  end

  // EOC wait timer; cleared in START so it is zero on WAIT_EOC entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= '0;
    else if (state == START)
      timer <= '0;
    else if (state == WAIT_EOC && !eoc && timer != TMR_LAST)
      timer <= timer + 1'b1;
  end

  // Sticky error flag: set on timeout, cleared only when a new run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == IDLE && init)
      err_q <= 1'b0;
    else if (state == WAIT_EOC && nxt == ERR)
      err_q <= 1'b1;
  end

  // ADC data capture at the end of the READ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_data <= '0;
    else if (state == READ)
      mem_data <= adc_data;
  end

  assign sc       = (state == START);
  assign cs       = (state == START) || (state == WAIT_EOC) || (state == READ);
  assign rc       = (state == READ);
  assign w        = (state == WRITE);
  assign ack      = (state == DONE) || (state == ERR);
  assign busy     = (state == START) || (state == WAIT_EOC) ||
                    (state == READ)  || (state == WRITE);
  assign err      = err_q;
  assign mem_addr = count;

endmodule

// File: tb/tb_adq_seq_ctrl.sv
// Directed bench for adq_seq_ctrl with N_SAMPLES=4, SC_CYCLES=2, EOC_TIMEOUT=8.
module tb_adq_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       abort;
  logic       eoc;
  logic [7:0] adc_data;
  logic       sc;
  logic       cs;
  logic       rc;
  logic       w;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       ack;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wcount   = 0;
  int w0       = 0;

  logic [7:0] nom_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  adq_seq_ctrl #(
    .N_SAMPLES   (4),
    .ADDR_W      (4),
    .DATA_W      (8),
    .SC_CYCLES   (2),
    .EOC_TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .abort    (abort),
    .eoc      (eoc),
    .adc_data (adc_data),
    .sc       (sc),
    .cs       (cs),
    .rc       (rc),
    .w        (w),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .ack      (ack),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count memory write pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (w === 1'b1)
      wcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample from START cycle 1 through WRITE, ending in the following state.
  // pulse=1: eoc is raised for the k-th WAIT_EOC cycle only.
  task automatic sample(input int s, input int k, input logic [7:0] d, input bit pulse);
    adc_data = d;
    chk("start1_sc_cs", 32'({sc, cs, busy}), 32'b111);
    chk("start1_addr", 32'(mem_addr), s);
    tick();
    chk("start2_sc", 32'({sc, cs}), 32'b11);
    for (int j = 1; j <= k; j++) begin
      tick();
      chk("wait_sc_cs_rc", 32'({sc, cs, rc}), 32'b010);
      if (pulse && j == k)
        eoc = 1'b1;
    end
    tick();
    chk("read_cs_rc_w", 32'({cs, rc, w}), 32'b110);
    if (pulse)
      eoc = 1'b0;
    tick();
    chk("write_w_rc_busy", 32'({w, rc, busy}), 32'b101);
    chk("write_addr", 32'(mem_addr), s);
    chk("write_data", 32'(mem_data), 32'(d));
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    init     = 1'b0;
    abort    = 1'b0;
    eoc      = 1'b0;
    adc_data = 8'h00;
    #12;
    chk("reset_outs", 32'({sc, cs, rc, w, ack, busy, err}), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_data", 32'(mem_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("idle_outs", 32'({sc, cs, rc, w, ack, busy, err}), 32'd0);

    // Nominal run: eoc on the 3rd WAIT_EOC cycle, 7 clocks per sample.
    w0   = wcount;
    init = 1'b1;
    tick();
    cyc = 0;
    for (int s = 0; s < 4; s++)
      sample(s, 3, nom_d[s], 1'b1);
    chk("nom_latency", cyc, 28);
    chk("nom_ack_busy_err", 32'({ack, busy, err}), 32'b100);
    chk("nom_wcount", wcount - w0, 4);
    tick();
    chk("nom_ack_hold", 32'(ack), 1);
    init = 1'b0;
    tick();
    chk("nom_ack_fall", 32'({ack, busy}), 32'b00);

    // eoc held high: one WAIT_EOC cycle, 5 clocks per sample.
    eoc  = 1'b1;
    init = 1'b1;
    tick();
    cyc = 0;
    for (int s = 0; s < 4; s++)
      sample(s, 1, 8'(8'h50 + s), 1'b0);
    chk("hold_latency", cyc, 20);
    chk("hold_ack", 32'(ack), 1);
    init = 1'b0;
    eoc  = 1'b0;
    tick();
    chk("hold_ack_fall", 32'(ack), 0);

    // eoc never arrives: ERR after 8 WAIT_EOC cycles.
    w0   = wcount;
    init = 1'b1;
    tick();
    chk("to_start", 32'(sc), 1);
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("to_wait", 32'({cs, busy, ack}), 32'b110);
    end
    tick();
    chk("to_err_state", 32'({ack, err, busy, cs}), 32'b1100);
    chk("to_no_write", wcount - w0, 0);
    tick();
    chk("to_err_hold", 32'({ack, err}), 32'b11);
    init = 1'b0;
    tick();
    chk("to_idle_err_kept", 32'({ack, err}), 32'b01);
    init = 1'b1;
    tick();
    chk("to_new_run_clears", 32'({err, busy}), 32'b01);
    abort = 1'b1;
    init  = 1'b0;
    tick();
    abort = 1'b0;
    chk("to_abort_idle", 32'(busy), 0);

    // Abort in WAIT_EOC of sample 2, together with eoc.
    w0   = wcount;
    init = 1'b1;
    tick();
    sample(0, 1, 8'hA0, 1'b1);
    sample(1, 1, 8'hA1, 1'b1);
    tick();
    tick();
    chk("ab_in_wait", 32'({sc, cs}), 32'b01);
    abort = 1'b1;
    eoc   = 1'b1;
    init  = 1'b0;
    tick();
    chk("ab_idle", 32'({sc, cs, rc, busy, ack, err}), 32'd0);
    chk("ab_wcount", wcount - w0, 2);
    abort = 1'b0;
    eoc   = 1'b0;
    tick();
    chk("ab_stay_idle", 32'({busy, ack}), 32'b00);

    // Asynchronous reset in the middle of READ.
    w0       = wcount;
    init     = 1'b1;
    adc_data = 8'h5A;
    tick();
    tick();
    tick();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("rst_in_read", 32'(rc), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", 32'({sc, cs, rc, w, ack, busy, err}), 32'd0);
    chk("rst_async_addr_data", 32'({mem_addr, mem_data}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rst_fresh_start", 32'({sc, busy}), 32'b11);
    chk("rst_fresh_addr", 32'(mem_addr), 0);
    chk("rst_no_write", wcount - w0, 0);
    abort = 1'b1;
    init  = 1'b0;
    tick();
    abort = 1'b0;

    // init dropped during the first sample: run completes, one-cycle ack.
    w0   = wcount;
    eoc  = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int s = 0; s < 4; s++)
      sample(s, 1, 8'(8'hC0 + s), 1'b0);
    chk("drop_ack", 32'({ack, busy}), 32'b10);
    chk("drop_wcount", wcount - w0, 4);
    eoc = 1'b0;
    tick();
    chk("drop_ack_one_cycle", 32'({ack, busy}), 32'b00);
    tick();
    chk("drop_idle", 32'({ack, busy, sc}), 32'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
